// File: rtl/nzaa_pkg.sv
// nzaa_pkg: shared states, widths and the round/clip helper for the MAC array
package nzaa_pkg;
   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_e;
   localparam int PIPE_DEPTH = 3;
   localparam int DEF_LANES = 16;
   localparam int DEF_DW = 16;
   localparam int DEF_FRAC = 8;
   localparam int DEF_ACC_W = 40;
   localparam int DEF_CNT_W = 16;
   function automatic logic signed [127:0] round_sat(input logic signed [127:0] acc, input int frac, input int dw);
      logic signed [127:0] r, hi, lo;
      r = (acc + (128'sd1 <<< (frac - 1))) >>> frac;
      hi = (128'sd1 <<< (dw - 1)) - 128'sd1;
      lo = -(128'sd1 <<< (dw - 1));
      return (r > hi) ? hi : (r < lo) ? lo : r;
   endfunction
endpackage

// File: rtl/nzaa_lane.sv
// nzaa_lane: one output neuron -- product, saturating accumulator, ovf flag, rounded result
module nzaa_lane import nzaa_pkg::*; #(
   parameter int DW = DEF_DW,
   parameter int FRAC = DEF_FRAC,
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic                 clk_h,
   input  logic                 rst_n,
   input  logic                 clr_i,
   input  logic                 skip_i,
   input  logic                 acc_en_i,
   input  logic                 ld_i,
   input  logic signed [DW-1:0] d_i,
   input  logic signed [DW-1:0] w_i,
   output logic [DW-1:0]        data_o,
   output logic                 ovf_o
);
   logic signed [2*DW-1:0] prod, p_d, p_q;
   logic signed [ACC_W-1:0] acc_d, acc_q;
   logic [ACC_W:0] sum;
   logic sat, ovf_d, ovf_q;
   logic [DW-1:0] data_d, data_q;
   always_comb begin
      prod = d_i * w_i;
      p_d = skip_i ? '0 : prod;
      sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-2*DW){p_q[2*DW-1]}}, p_q};
      sat = sum[ACC_W] ^ sum[ACC_W-1];
      acc_d = clr_i ? '0
            : !acc_en_i ? acc_q
            : !sat ? sum[ACC_W-1:0]
            : sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      ovf_d = clr_i ? 1'b0 : ovf_q | (acc_en_i & sat);
      data_d = ld_i ? DW'(round_sat(128'(acc_q), FRAC, DW)) : data_q;
   end
   always_ff @(posedge clk_h or negedge rst_n)
      if (!rst_n) begin
         p_q <= '0;
         acc_q <= '0;
         ovf_q <= 1'b0;
         data_q <= '0;
      end else begin
         p_q <= p_d;
         acc_q <= acc_d;
         ovf_q <= ovf_d;
         data_q <= data_d;
      end
   assign data_o = data_q;
   assign ovf_o = ovf_q;
endmodule

// File: rtl/nzaa_mac_array.sv
// nzaa_mac_array: streaming multi-lane MAC with magnitude-threshold skipping and a held result
module nzaa_mac_array import nzaa_pkg::*; #(
   parameter int LANES = DEF_LANES,
   parameter int DW = DEF_DW,
   parameter int FRAC = DEF_FRAC,
   parameter int ACC_W = DEF_ACC_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                  clk_h,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic [4:0]            th,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DW-1:0]         data_in,
   input  logic [LANES*DW-1:0]   weight_in,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LANES*DW-1:0]   data_out,
   output logic [LANES-1:0]      ovf,
   output logic [CNT_W-1:0]      skip_cnt,
   output logic [CNT_W-1:0]      mac_cnt
);
   state_e state_d, state_q;
   logic [PIPE_DEPTH-1:0] v_q;
   logic signed [DW-1:0] d1_q;
   logic [LANES*DW-1:0] w1_q;
   logic s1_q, acc_ok, busy, clr, ld, skip;
   logic [DW:0] mag;
   logic [4:0] th_e;
   logic [CNT_W-1:0] sk_b, mc_b, skip_d, skip_q, mac_d, mac_q;
   assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
   assign out_valid = state_q == HOLD;
   assign skip_cnt = skip_q;
   assign mac_cnt = mac_q;
   // thresholds at or above DW-1 behave as DW-1 so only the most negative value survives
   always_comb begin
      acc_ok = in_valid && in_ready;
      busy = |v_q;
      clr = in_ready && clear && !busy;
      ld = (state_q == DRAIN) && !busy;
      mag = data_in[DW-1] ? ~{1'b1, data_in} + 1'b1 : {1'b0, data_in};
      th_e = (int'(th) > DW - 1) ? 5'(DW - 1) : th;
      skip = (mag >> th_e) == '0;
      sk_b = clr ? '0 : skip_q;
      mc_b = clr ? '0 : mac_q;
      skip_d = sk_b + CNT_W'(acc_ok && skip && !(&sk_b));
      mac_d = mc_b + CNT_W'(acc_ok && !skip && !(&mc_b));
      state_d = (state_q == IDLE) ? (acc_ok ? (in_last ? DRAIN : ACCUM) : IDLE)
              : (state_q == ACCUM) ? ((acc_ok && in_last) ? DRAIN : ACCUM)
              : (state_q == DRAIN) ? (busy ? DRAIN : HOLD)
              : (out_ready ? IDLE : HOLD);
   end
   always_ff @(posedge clk_h or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         v_q <= '0;
         d1_q <= '0;
         w1_q <= '0;
         s1_q <= 1'b0;
         skip_q <= '0;
         mac_q <= '0;
      end else begin
         state_q <= state_d;
         v_q <= {v_q[PIPE_DEPTH-2:0], acc_ok};
         skip_q <= skip_d;
         mac_q <= mac_d;
         if (acc_ok) begin
            d1_q <= data_in;
            w1_q <= weight_in;
            s1_q <= skip;
         end
      end
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      nzaa_lane #(.DW(DW), .FRAC(FRAC), .ACC_W(ACC_W)) u_lane (
         .clk_h(clk_h),
         .rst_n(rst_n),
         .clr_i(clr),
         .skip_i(s1_q),
         .acc_en_i(v_q[1]),
         .ld_i(ld),
         .d_i(d1_q),
         .w_i(w1_q[k*DW +: DW]),
         .data_o(data_out[k*DW +: DW]),
         .ovf_o(ovf[k])
      );
   end
endmodule

// File: tb/tb_nzaa_mac_array.sv
// tb_nzaa_mac_array: directed scoreboard bench for nzaa_mac_array
module tb_nzaa_mac_array;
   localparam int LANES = 16, DW = 16, FRAC = 8, ACC_W = 40, CNT_W = 16;
   logic clk_h, rst_n, clear, in_valid, in_ready, in_last, out_valid, out_ready;
   logic [4:0] th;
   logic [DW-1:0] data_in;
   logic [LANES*DW-1:0] weight_in, data_out, wv;
   logic [LANES-1:0] ovf;
   logic [CNT_W-1:0] skip_cnt, mac_cnt;
   typedef struct packed {
      logic [LANES*DW-1:0] data;
      logic [LANES-1:0] ovf;
      logic [CNT_W-1:0] sk;
      logic [CNT_W-1:0] mc;
   } exp_t;
   exp_t sbq[$];
   longint m_acc[LANES];
   logic [LANES-1:0] m_ovf;
   int m_sk, m_mc, n_cmp, n_bad;

   nzaa_mac_array #(.LANES(LANES), .DW(DW), .FRAC(FRAC), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk_h(clk_h), .rst_n(rst_n), .clear(clear), .th(th), .in_valid(in_valid),
      .in_ready(in_ready), .data_in(data_in), .weight_in(weight_in), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .ovf(ovf),
      .skip_cnt(skip_cnt), .mac_cnt(mac_cnt)
   );

   initial clk_h = 1'b0;
   always #5 clk_h = ~clk_h;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] m_round(input longint a);
      longint r;
      r = (a + (longint'(1) << (FRAC - 1))) >>> FRAC;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return r[DW-1:0];
   endfunction

   task automatic set_w(input logic [DW-1:0] w);
      for (int k = 0; k < LANES; k++) wv[k*DW +: DW] = w;
   endtask

   task automatic m_reset();
      for (int k = 0; k < LANES; k++) m_acc[k] = 0;
      m_ovf = '0;
      m_sk = 0;
      m_mc = 0;
   endtask

   task automatic beat(input logic [DW-1:0] d, input logic last, input logic [4:0] t, input logic clr, input int gap);
      logic ok, sk;
      int dv, mag, te;
      longint p, s, hi, lo;
      exp_t e;
      in_valid = 1'b0;
      clear = 1'b0;
      repeat (gap) begin @(posedge clk_h); #1; end
      in_valid = 1'b1; data_in = d; weight_in = wv; in_last = last; th = t; clear = clr;
      @(negedge clk_h);
      ok = in_ready;
      chk("accept", ok, 1'b1);
      @(posedge clk_h);
      if (ok) begin
         if (clr) m_reset();
         dv = int'($signed(d));
         mag = dv < 0 ? -dv : dv;
         te = int'(t) > DW - 1 ? DW - 1 : int'(t);
         sk = mag < (1 << te);
         if (sk) m_sk = m_sk < 65535 ? m_sk + 1 : m_sk;
         else m_mc = m_mc < 65535 ? m_mc + 1 : m_mc;
         hi = (longint'(1) << (ACC_W - 1)) - 1;
         lo = -(longint'(1) << (ACC_W - 1));
         for (int k = 0; k < LANES; k++) begin
            p = sk ? 0 : longint'(dv) * longint'($signed(wv[k*DW +: DW]));
            s = m_acc[k] + p;
            if (s > hi) begin s = hi; m_ovf[k] = 1'b1; end
            if (s < lo) begin s = lo; m_ovf[k] = 1'b1; end
            m_acc[k] = s;
         end
         if (last) begin
            for (int k = 0; k < LANES; k++) e.data[k*DW +: DW] = m_round(m_acc[k]);
            e.ovf = m_ovf;
            e.sk = m_sk[CNT_W-1:0];
            e.mc = m_mc[CNT_W-1:0];
            sbq.push_back(e);
         end
      end
      #1;
      in_valid = 1'b0; clear = 1'b0; in_last = 1'b0;
   endtask

   task automatic get_result(input int hold, input logic hold_clear);
      int n;
      exp_t e;
      logic [LANES*DW-1:0] d0;
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk_h); n++; end
      chk("latency", n - 1, 4);
      if (sbq.size() == 0) begin
         chk("scoreboard_empty", 1'b1, 1'b0);
      end else begin
         e = sbq.pop_front();
         chk("data_out", data_out, e.data);
         chk("ovf", ovf, e.ovf);
         chk("skip_cnt", skip_cnt, e.sk);
         chk("mac_cnt", mac_cnt, e.mc);
         if (hold > 0) begin
            d0 = data_out;
            clear = hold_clear;
            repeat (hold) begin
               @(negedge clk_h);
               chk("hold_in_ready", in_ready, 1'b0);
               chk("hold_out_valid", out_valid, 1'b1);
               chk("hold_data", data_out, d0);
            end
            clear = 1'b0;
            chk("hold_skip_cnt", skip_cnt, e.sk);
            chk("hold_mac_cnt", mac_cnt, e.mc);
            chk("hold_ovf", ovf, e.ovf);
         end
      end
      out_ready = 1'b1;
      @(posedge clk_h); #1;
      out_ready = 1'b0;
      chk("released", out_valid, 1'b0);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      rst_n = 1'b0; clear = 1'b0; th = '0; in_valid = 1'b0; data_in = '0;
      weight_in = '0; in_last = 1'b0; out_ready = 1'b0; wv = '0;
      m_reset();
      #23;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_data_out", data_out, '0);
      chk("rst_ovf", ovf, '0);
      chk("rst_skip_cnt", skip_cnt, '0);
      chk("rst_mac_cnt", mac_cnt, '0);
      @(posedge clk_h); #1;
      rst_n = 1'b1;
      @(posedge clk_h); #1;

      set_w(16'h0200);
      for (int i = 0; i < 4; i++) beat(16'h0100, i == 3, 5'd0, i == 0, 0);
      get_result(0, 1'b0);
      chk("basic_lane0", data_out[15:0], 16'h0800);

      set_w(16'h0100);
      wv[15:0] = 16'h0300;
      wv[31:16] = 16'hFD00;
      beat(16'hFF00, 1'b1, 5'd0, 1'b1, 0);
      get_result(0, 1'b0);
      chk("signed_lane0", data_out[15:0], 16'hFD00);
      chk("signed_lane1", data_out[31:16], 16'h0300);

      set_w(16'h0100);
      beat(16'h000F, 1'b0, 5'd4, 1'b1, 0);
      beat(16'h0010, 1'b1, 5'd4, 1'b0, 0);
      get_result(0, 1'b0);
      chk("th4_lane3", data_out[63:48], 16'h0010);
      beat(16'h000F, 1'b0, 5'd0, 1'b1, 0);
      beat(16'h0010, 1'b1, 5'd0, 1'b0, 0);
      get_result(0, 1'b0);
      chk("th0_lane3", data_out[63:48], 16'h001F);

      beat(16'h7FFF, 1'b0, 5'd20, 1'b1, 0);
      beat(16'h8000, 1'b0, 5'd20, 1'b0, 0);
      beat(16'h0000, 1'b1, 5'd0, 1'b0, 0);
      get_result(0, 1'b0);
      chk("th_max_lane0", data_out[15:0], 16'h8000);

      set_w(16'h0200);
      for (int i = 0; i < 4; i++) beat(16'h0100, i == 3, 5'd0, i == 0, int'($urandom_range(0, 3)));
      get_result(10, 1'b1);
      chk("gap_lane15", data_out[255:240], 16'h0800);

      set_w(16'h7FFF);
      for (int i = 0; i < 4096; i++) beat(16'h7FFF, i == 4095, 5'd0, i == 0, 0);
      get_result(0, 1'b0);
      chk("sat_pos_lane0", data_out[15:0], 16'h7FFF);
      set_w(16'h8000);
      for (int i = 0; i < 4096; i++) beat(16'h7FFF, i == 4095, 5'd0, i == 0, 0);
      get_result(0, 1'b0);
      chk("sat_neg_lane0", data_out[15:0], 16'h8000);

      set_w(16'h0300);
      for (int i = 0; i < 100; i++) beat(16'h0100, 1'b0, 5'd0, i == 0, 0);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_data_out", data_out, '0);
      chk("midrst_ovf", ovf, '0);
      chk("midrst_mac_cnt", mac_cnt, '0);
      chk("midrst_in_ready", in_ready, 1'b1);
      m_reset();
      @(posedge clk_h); #1;
      rst_n = 1'b1;
      @(posedge clk_h); #1;
      set_w(16'h0200);
      for (int i = 0; i < 4; i++) beat(16'h0100, i == 3, 5'd0, 1'b0, 0);
      get_result(0, 1'b0);
      chk("post_rst_lane7", data_out[127:112], 16'h0800);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
